cr_cg_ib_arb: RTL and testbench
===============================

// Module: cr_cg_ib_arb
// PURPOSE
//  Frame-granular round-robin arbiter that shares the single CG inbound AXI4-stream datapath among N requesters.
//  Sits in front of the CG core inbound port.
//  Selects one requester per frame, passes its beats through a 2-entry skid buffer and releases the grant only after tlast.
//  Never interleaves beats from different requesters.
// PARAMETERS
//  N_REQ     4    number of requesters, 2..8
//  DATA_W    64   tdata width
//  USER_W    8    tuser width (carried with tdata, not interpreted)
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              asynchronous active-low reset
//  in_tvalid     in   N_REQ          per-requester beat valid
//  in_tlast      in   N_REQ          per-requester end of frame
//  in_tdata      in   N_REQ*DATA_W   requester i at [i*DATA_W +: DATA_W]
//  in_tuser      in   N_REQ*USER_W   requester i at [i*USER_W +: USER_W]
//  in_tready     out  N_REQ          per-requester ready; at most one bit set
//  out_tvalid    out  1              beat valid toward CG core
//  out_tlast     out  1              end of frame
//  out_tdata     out  DATA_W         beat data
//  out_tuser     out  USER_W         beat user
//  out_tid       out  3              index of requester that owns the beat
//  out_tready    in   1              CG core ready
//  cfg_req_en    in   N_REQ          requester enable mask from regfile
//  busy          out  1              1 while state==PASS or skid buffer non-empty
// BEHAVIOUR
//  Clocking and reset
//   - Single clock domain.
//   - Reset is asynchronous and active-low (rst_n). All flops clear on rst_n=0.
//   - Reset values: state=IDLE, grant=0, last_grant=N_REQ-1, skid empty.
//   - Outputs at reset: out_tvalid=0, out_tlast=0, out_tdata=0, out_tuser=0, out_tid=0, in_tready=0, busy=0.
//  FSM
//   - IDLE: in_tready=0.
//     - eligible = in_tvalid & cfg_req_en.
//     - If eligible!=0, grant is the first eligible index after last_grant, searched cyclically (wraps N_REQ-1 -> 0).
//     - grant is registered, then the FSM moves to PASS. The arbitration bubble is one cycle.
//   - PASS: in_tready[grant] = skid_not_full; all other bits are 0.
//     - A beat is accepted when in_tvalid[grant] & in_tready[grant]. It is pushed into the skid with tid=grant.
//     - An accepted beat with in_tlast[grant]=1 sets last_grant<=grant and returns to IDLE next cycle.
//  Skid buffer
//   - 2 entries, FIFO order. out_* are driven from the head entry register; there is no combinational in->out path.
//   - skid_not_full is registered (entries<2), so in_tready does not depend combinationally on out_tready.
//   - Push and pop in the same cycle: the occupancy count is unchanged.
//   - Full throughput: 1 beat/cycle with out_tready held at 1.
//  Latency
//   - A beat accepted at edge k appears on out_tvalid from cycle k+1.
//   - The first beat of a frame: in_tvalid rises in IDLE at cycle 0 -> grant at edge 0 -> accepted at edge 1 -> out_tvalid in cycle 2.
//  Frame gap
//   - Back-to-back frames carry exactly one idle input cycle between the tlast acceptance and the next grant.
//  Boundary cases
//   - cfg_req_en changes during PASS do not abort the frame; the mask is sampled only in IDLE.
//   - in_tvalid from a non-granted requester is ignored, and its in_tready stays 0.
//   - Granted requester drops tvalid mid-frame: the grant is held indefinitely (no timeout).
//   - out_tready=0 with skid full: in_tready=0, and out_* hold stable until the pop.
//   - Single eligible requester: it is re-granted every frame.
//   - Reset asserted mid-frame: the partial frame is discarded and the skid is flushed; the source must resend.
// CONFIGURATION
//  CR_CG_IB_ARB_STATS_EN
//  - Defined: adds these ports.
//    - stat_frame_cnt   out  N_REQ*16  frames forwarded per requester, counted at out tlast pop.
//      Saturates at 16'hFFFF; reset to 0.
//    - stat_clr         in   1         synchronous clear of all counters; clear wins over a same-cycle increment.
//  - Undefined: these ports and the counter logic do not exist, and behaviour is otherwise identical.
// TESTING
//  - Reset: hold rst_n=0 mid-frame for 3 cycles.
//    -> out_tvalid=0, in_tready=0, busy=0. After release, requester 0 wins first.
//  - Round robin: N_REQ=4, all cfg_req_en=1, requesters 0..3 each send 3-beat frames continuously, out_tready=1.
//    -> out_tid sequence 0,0,0,1,1,1,2,2,2,3,3,3,0...
//    -> exactly 1 bubble input cycle between frames.
//  - Backpressure: out_tready toggled 1,0,0,1 pattern.
//    -> no beat lost or duplicated.
//    -> in_tready[grant] falls only when the skid holds 2 entries.
//    -> out_* stable while out_tvalid & !out_tready.
//  - Masking: cfg_req_en=4'b1010, all valid.
//    -> grants alternate 1,3,1,3.
//    -> clearing bit 1 during requester 1's frame still completes that frame.
//  - Single-beat frames: tlast on every beat from requesters 2 and 3.
//    -> grants 2,3,2,3; throughput 1 beat per 2 cycles.
//  - Stats (CR_CG_IB_ARB_STATS_EN): 70000 frames on requester 0.
//    -> stat_frame_cnt[15:0]=16'hFFFF.
//    -> stat_clr with a same-cycle tlast pop -> 0.

Source files
------------

// File: rtl/cr_cg_ib_arb.sv
// Frame-granular round-robin arbiter feeding the CG core inbound AXI4-stream port through a 2-entry skid.
// Optional per-requester frame counters are enabled by defining CR_CG_IB_ARB_STATS_EN.
module cr_cg_ib_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    parameter int USER_W = 8
) (
`ifdef CR_CG_IB_ARB_STATS_EN
    output logic [N_REQ*16-1:0]     stat_frame_cnt,
    input  logic                    stat_clr,
`endif
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        in_tvalid,
    input  logic [N_REQ-1:0]        in_tlast,
    input  logic [N_REQ*DATA_W-1:0] in_tdata,
    input  logic [N_REQ*USER_W-1:0] in_tuser,
    output logic [N_REQ-1:0]        in_tready,
    output logic                    out_tvalid,
    output logic                    out_tlast,
    output logic [DATA_W-1:0]       out_tdata,
    output logic [USER_W-1:0]       out_tuser,
    output logic [2:0]              out_tid,
    input  logic                    out_tready,
    input  logic [N_REQ-1:0]        cfg_req_en,
    output logic                    busy
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, PASS} state_t;

    typedef struct packed {
        logic              last;
        logic [GW-1:0]     tid;
        logic [USER_W-1:0] user;
        logic [DATA_W-1:0] data;
    } ent_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          full_q;
    ent_t          head_q, head_d, tail_q, tail_d;

    logic [N_REQ-1:0] elig;
    logic [GW-1:0]    pick;
    logic             found_hi;
    logic [GW-1:0]    pick_hi, pick_lo;
    logic             sel_vld;
    ent_t             new_ent;
    logic             push, pop;

    assign elig = in_tvalid & cfg_req_en;

    // Lowest eligible index above last_grant wins; otherwise wrap to the lowest eligible index.
    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick_lo = GW'(i);
                if (i > int'(last_grant_q)) begin
                    pick_hi  = GW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        sel_vld = 1'b0;
        new_ent = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_vld      = in_tvalid[i];
                new_ent.last = in_tlast[i];
                new_ent.data = in_tdata[i*DATA_W +: DATA_W];
                new_ent.user = in_tuser[i*USER_W +: USER_W];
            end
        end
        new_ent.tid = grant_q;
    end

    always_comb begin
        in_tready = '0;
        if (state_q == PASS) begin
            for (int i = 0; i < N_REQ; i++) begin
                in_tready[i] = (grant_q == GW'(i)) && !full_q;
            end
        end
    end

    assign push = (state_q == PASS) && sel_vld && !full_q;
    assign pop  = (cnt_q != 2'd0) && out_tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    grant_d = pick;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (push && new_ent.last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = new_ent;
                else               tail_d = new_ent;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = new_ent;
                end else begin
                    head_d = tail_q;
                    tail_d = new_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            cnt_q        <= 2'd0;
            full_q       <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            full_q       <= (cnt_d == 2'd2);
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    assign out_tvalid = (cnt_q != 2'd0);
    assign out_tlast  = head_q.last;
    assign out_tdata  = head_q.data;
    assign out_tuser  = head_q.user;
    assign out_tid    = 3'(head_q.tid);
    assign busy       = (state_q == PASS) || (cnt_q != 2'd0);

`ifdef CR_CG_IB_ARB_STATS_EN
    logic [15:0] stat_q [N_REQ];

    // Frames are counted when their last beat leaves toward the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stat_clr) begin
                    stat_q[i] <= '0;
                end else if (pop && head_q.last && (head_q.tid == GW'(i)) && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_frame_cnt[g*16 +: 16] = stat_q[g];
    end
`endif
endmodule

// File: tb/tb_cr_cg_ib_arb.sv
// Directed bench for cr_cg_ib_arb: reset, round robin, backpressure, masking, single-beat frames, mid-frame reset.
module tb_cr_cg_ib_arb;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int UW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    in_tvalid, in_tlast, in_tready;
    logic [N*DW-1:0] in_tdata;
    logic [N*UW-1:0] in_tuser;
    logic            out_tvalid, out_tlast, out_tready;
    logic [DW-1:0]   out_tdata;
    logic [UW-1:0]   out_tuser;
    logic [2:0]      out_tid;
    logic [N-1:0]    cfg_req_en;
    logic            busy;
`ifdef CR_CG_IB_ARB_STATS_EN
    logic            stat_clr;
    logic [N*16-1:0] stat_frame_cnt;
`endif

    cr_cg_ib_arb #(.N_REQ(N), .DATA_W(DW), .USER_W(UW)) dut (
`ifdef CR_CG_IB_ARB_STATS_EN
        .stat_frame_cnt (stat_frame_cnt),
        .stat_clr       (stat_clr),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tdata   (in_tdata),
        .in_tuser   (in_tuser),
        .in_tready  (in_tready),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tdata  (out_tdata),
        .out_tuser  (out_tuser),
        .out_tid    (out_tid),
        .out_tready (out_tready),
        .cfg_req_en (cfg_req_en),
        .busy       (busy)
    );

    int n_asrt = 0;
    int n_fail = 0;

    int           src_len [N];
    int           src_b   [N];
    int           src_f   [N];
    logic [N-1:0] src_on;
    int           exp_tid [16];

    int            cyc, occ, full_seen;
    logic          mid_frame, stall_prev;
    logic [DW-1:0] prev_dat;
    logic [UW-1:0] prev_user;
    logic [2:0]    prev_tid;
    logic          prev_last;
    logic [3:0]    bp_pat;

    logic [2:0]    pop_tid  [$];
    logic [DW-1:0] pop_dat  [$];
    logic [UW-1:0] pop_user [$];
    logic          pop_last [$];
    int            pop_cyc  [$];
    int            acc_cyc  [$];
    int            acc_req  [$];

    // Source beat = {requester, frame number, beat number}.
    always_comb begin
        in_tvalid = src_on;
        in_tlast  = '0;
        in_tdata  = '0;
        in_tuser  = '0;
        for (int i = 0; i < N; i++) begin
            in_tlast[i]            = (src_b[i] == src_len[i] - 1);
            in_tdata[i*DW +: DW]   = {32'(i), 16'(src_f[i]), 16'(src_b[i])};
            in_tuser[i*UW +: UW]   = {4'(i), 4'(src_b[i])};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_out_tvalid", 64'(out_tvalid), 64'(0));
            chk("rst_out_tlast",  64'(out_tlast),  64'(0));
            chk("rst_out_tdata",  64'(out_tdata),  64'(0));
            chk("rst_out_tuser",  64'(out_tuser),  64'(0));
            chk("rst_out_tid",    64'(out_tid),    64'(0));
            chk("rst_in_tready",  64'(in_tready),  64'(0));
            chk("rst_busy",       64'(busy),       64'(0));
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        occ        = 0;
        mid_frame  = 1'b0;
        stall_prev = 1'b0;
        cyc        = -1;
        for (int i = 0; i < N; i++) begin
            src_b[i] = 0;
            src_f[i] = 0;
        end
        pop_tid.delete(); pop_dat.delete(); pop_user.delete(); pop_last.delete(); pop_cyc.delete();
        acc_cyc.delete(); acc_req.delete();
    endtask

    task automatic run_cycle();
        logic [N-1:0] acc;
        logic         pop;
        @(negedge clk);
        cyc++;
        chk("ready_onehot0", 64'($onehot0(in_tready)), 64'(1));
        chk("valid_vs_occupancy", 64'(out_tvalid), 64'(occ != 0));
        if (occ == 2) chk("ready_low_when_full", 64'(in_tready), 64'(0));
        if (mid_frame && in_tready == '0) begin
            full_seen++;
            chk("ready_drop_only_full", 64'(occ), 64'(2));
        end
        if (stall_prev) begin
            chk("hold_tdata", out_tdata, prev_dat);
            chk("hold_tuser", 64'(out_tuser), 64'(prev_user));
            chk("hold_tid",   64'(out_tid),   64'(prev_tid));
            chk("hold_tlast", 64'(out_tlast), 64'(prev_last));
        end
        acc = in_tvalid & in_tready;
        pop = out_tvalid & out_tready;
        if (pop) begin
            pop_tid.push_back(out_tid);
            pop_dat.push_back(out_tdata);
            pop_user.push_back(out_tuser);
            pop_last.push_back(out_tlast);
            pop_cyc.push_back(cyc);
        end
        stall_prev = out_tvalid & ~out_tready;
        prev_dat   = out_tdata;
        prev_user  = out_tuser;
        prev_tid   = out_tid;
        prev_last  = out_tlast;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                acc_cyc.push_back(cyc);
                acc_req.push_back(i);
                mid_frame = !in_tlast[i];
            end
        end
        occ = occ + ((acc != '0) ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (src_b[i] == src_len[i] - 1) begin
                    src_b[i] = 0;
                    src_f[i]++;
                end else begin
                    src_b[i]++;
                end
            end
        end
    endtask

    task automatic check_stream(input string tag, input int n, input int len);
        int ef [N];
        int eb [N];
        for (int i = 0; i < N; i++) begin
            ef[i] = 0;
            eb[i] = 0;
        end
        chk({tag, "_beat_count"}, 64'(pop_tid.size()), 64'(n));
        for (int j = 0; j < n && j < pop_tid.size(); j++) begin
            int t;
            t = exp_tid[j];
            chk({tag, "_tid"},   64'(pop_tid[j]),  64'(t));
            chk({tag, "_tdata"}, pop_dat[j],       {32'(t), 16'(ef[t]), 16'(eb[t])});
            chk({tag, "_tuser"}, 64'(pop_user[j]), 64'({4'(t), 4'(eb[t])}));
            chk({tag, "_tlast"}, 64'(pop_last[j]), 64'(eb[t] == len - 1));
            if (eb[t] == len - 1) begin
                eb[t] = 0;
                ef[t]++;
            end else begin
                eb[t]++;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        out_tready = 1'b1;
        cfg_req_en = '0;
        src_on     = '0;
        full_seen  = 0;
        bp_pat     = 4'b1001;
`ifdef CR_CG_IB_ARB_STATS_EN
        stat_clr   = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            src_len[i] = 3;
            src_b[i]   = 0;
            src_f[i]   = 0;
        end
        #2;

        // Round robin with latency and frame-gap checks.
        apply_reset();
        cfg_req_en = 4'b1111;
        src_on     = 4'b1111;
        for (int t = 0; t < 200 && pop_tid.size() < 13; t++) run_cycle();
        exp_tid = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 0};
        check_stream("rr", 13, 3);
        chk("rr_first_accept_cycle", 64'((acc_cyc.size() > 0) ? acc_cyc[0] : -1), 64'(1));
        chk("rr_first_out_cycle",    64'((pop_cyc.size() > 0) ? pop_cyc[0] : -1), 64'(2));
        for (int k = 0; k < 12 && k + 1 < acc_cyc.size(); k++)
            chk("rr_accept_spacing", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'((k % 3 == 2) ? 2 : 1));

        // Backpressure: out_tready 1,0,0,1 repeating.
        apply_reset();
        full_seen = 0;
        for (int t = 0; t < 400 && pop_tid.size() < 12; t++) begin
            out_tready = bp_pat[2'(t % 4)];
            run_cycle();
        end
        out_tready = 1'b1;
        check_stream("bp", 12, 3);
        chk("bp_skid_filled", 64'(full_seen != 0), 64'(1));

        // Mask 1010: grants alternate between 1 and 3.
        apply_reset();
        cfg_req_en = 4'b1010;
        for (int t = 0; t < 200 && pop_tid.size() < 12; t++) run_cycle();
        exp_tid = '{1, 1, 1, 3, 3, 3, 1, 1, 1, 3, 3, 3, 0, 0, 0, 0};
        check_stream("mask", 12, 3);

        // Clearing requester 1's enable mid-frame must not cut its frame short.
        apply_reset();
        cfg_req_en = 4'b1010;
        for (int t = 0; t < 20 && acc_req.size() < 1; t++) run_cycle();
        chk("mask_clr_first_req", 64'((acc_req.size() > 0) ? acc_req[0] : -1), 64'(1));
        cfg_req_en = 4'b1000;
        for (int t = 0; t < 200 && pop_tid.size() < 9; t++) run_cycle();
        exp_tid = '{1, 1, 1, 3, 3, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0};
        check_stream("mask_clr", 9, 3);

        // Single-beat frames from requesters 2 and 3.
        apply_reset();
        cfg_req_en = 4'b1111;
        src_on     = 4'b1100;
        src_len[2] = 1;
        src_len[3] = 1;
        for (int t = 0; t < 100 && pop_tid.size() < 4; t++) run_cycle();
        exp_tid = '{2, 3, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_stream("single", 4, 1);
        for (int k = 0; k < 3 && k + 1 < acc_cyc.size(); k++)
            chk("single_accept_spacing", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'(2));

        // Reset in the middle of requester 0's frame; the source resends from beat 0.
        src_len[2] = 3;
        src_len[3] = 3;
        apply_reset();
        src_on = 4'b1111;
        for (int t = 0; t < 20 && acc_cyc.size() < 2; t++) run_cycle();
        chk("midrst_busy_before", 64'(busy), 64'(1));
        apply_reset();
        for (int t = 0; t < 100 && pop_tid.size() < 3; t++) run_cycle();
        exp_tid = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_stream("midrst", 3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
